icap_loader: RTL and testbench

ICAP_LOADER -- requirements
Module: icap_loader

---
 rtl/icap_loader_pkg.sv | 28 ++
 rtl/icap_loader.sv | 163 ++++++++++++++++
 tb/tb_icap_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icap_loader_pkg.sv
// Shared definitions for the xillybus user-side blocks: loader state encoding
// and the status codes reported to the host.
package icap_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_IDLE  = 2'b00;
  localparam logic [1:0] STATUS_LOAD  = 2'b01;
  localparam logic [1:0] STATUS_DONE  = 2'b10;
  localparam logic [1:0] STATUS_ERROR = 2'b11;

  // FLUSH is still a loading session as far as the host is concerned
  function automatic logic [1:0] state_status(input state_e s);
    case (s)
      ST_LOAD, ST_FLUSH: return STATUS_LOAD;
      ST_DONE:           return STATUS_DONE;
      ST_ERROR:          return STATUS_ERROR;
      default:           return STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/icap_loader.sv
// Streams bitstream words from the host FIFO into ICAP, with a one-entry skid
// register to absorb the in-flight word while ICAP is busy.
module icap_loader
  import icap_loader_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 1024,
  parameter bit BITSWAP      = 1'b1
) (
  input  logic        bus_clk,
  input  logic        trn_reset_n,
  input  logic        icap_open,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        icap_busy,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_i,
  output logic [1:0]  status,
  output logic [31:0] word_count
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_next;
  logic               r_open_d;
  logic               r_reopen;
  logic               r_fly;
  logic               r_pres_valid;
  logic [15:0]        r_pres_data;
  logic               r_skid_valid;
  logic [15:0]        r_skid_data;
  logic [CNT_W-1:0]   r_busy_cnt;
  logic [31:0]        r_word_count;

  logic               w_run;
  logic               w_rise;
  logic               w_held;
  logic               w_accept;
  logic               w_timeout;
  logic               w_drained;
  logic               w_enter_load;
  logic               w_drop;
  logic [15:0]        w_in_word;

  assign w_run        = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign w_rise       = icap_open & ~r_open_d;
  assign w_held       = w_run & r_pres_valid & icap_busy;
  assign w_accept     = w_run & r_pres_valid & ~icap_busy;
  assign w_timeout    = w_held & (r_busy_cnt == CNT_W'(BUSY_TIMEOUT - 1));
  assign w_drained    = fifo_empty & ~r_fly & ~r_skid_valid & ~r_pres_valid;
  assign w_enter_load = (w_next == ST_LOAD) && (r_state != ST_LOAD);
  assign w_drop       = ~w_run | (w_next == ST_ERROR);

  always_comb begin
    w_in_word = fifo_dout;
    if (BITSWAP) begin
      for (int b = 0; b < 8; b++) begin
        w_in_word[b]     = fifo_dout[7 - b];
        w_in_word[8 + b] = fifo_dout[15 - b];
      end
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_state  <= ST_IDLE;
      r_open_d <= 1'b0;
      r_reopen <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_open_d <= icap_open;
      if (w_enter_load)
        r_reopen <= 1'b0;
      else if ((r_state == ST_FLUSH) && w_rise)
        r_reopen <= 1'b1;
    end
  end

  // A reopen seen during FLUSH is remembered so DONE lasts exactly one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (icap_open) w_next = ST_LOAD;
      ST_LOAD:  if (w_timeout) w_next = ST_ERROR;
                else if (!icap_open) w_next = ST_FLUSH;
      ST_FLUSH: if (w_timeout) w_next = ST_ERROR;
                else if (w_drained) w_next = ST_DONE;
      ST_DONE:  if (w_rise || r_reopen) w_next = ST_LOAD;
      ST_ERROR: if (w_rise) w_next = ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    case (r_state)
      ST_LOAD, ST_FLUSH:
        fifo_rd_en = ~fifo_empty & ~r_skid_valid & ~(r_pres_valid & icap_busy);
      ST_ERROR:
        fifo_rd_en = ~fifo_empty;
      default:
        fifo_rd_en = 1'b0;
    endcase
    icap_ce_n  = ~(w_run & r_pres_valid);
    icap_wr_n  = ~(w_run & r_pres_valid);
    status     = state_status(r_state);
  end

  assign icap_i     = r_pres_data;
  assign word_count = r_word_count;

  // Presented word refills from the skid first; the in-flight word lands in the
  // skid only while the presented word is being held
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_fly        <= 1'b0;
      r_pres_valid <= 1'b0;
      r_pres_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      r_fly <= fifo_rd_en;
      if (w_drop) begin
        r_pres_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (!r_pres_valid || w_accept) begin
        if (r_skid_valid) begin
          r_pres_valid <= 1'b1;
          r_pres_data  <= r_skid_data;
          r_skid_valid <= r_fly;
          if (r_fly) r_skid_data <= w_in_word;
        end else if (r_fly) begin
          r_pres_valid <= 1'b1;
          r_pres_data  <= w_in_word;
        end else begin
          r_pres_valid <= 1'b0;
        end
      end else if (r_fly) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_in_word;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      r_busy_cnt   <= '0;
      r_word_count <= '0;
    end else begin
      if (w_held)
        r_busy_cnt <= r_busy_cnt + CNT_W'(1);
      else
        r_busy_cnt <= '0;
      if (w_enter_load)
        r_word_count <= '0;
      else if (w_accept)
        r_word_count <= r_word_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icap_loader.sv
// Directed bench for icap_loader: FIFO model, ICAP acceptance monitor and a
// linear sequence of checks with hand-derived expectations.
module tb_icap_loader;

  logic        bus_clk = 1'b0;
  logic        trn_reset_n;
  logic        icap_open;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        icap_busy;
  logic        icap_ce_n;
  logic        icap_wr_n;
  logic [15:0] icap_i;
  logic [1:0]  status;
  logic [31:0] word_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [15:0] acc_data [0:255];
  int          acc_cyc  [0:255];
  int          pop_cyc  [0:255];
  int          acc_n = 0;
  int          pop_n = 0;
  int          ce_low_n = 0;
  int          cyc = 0;

  icap_loader #(.BUSY_TIMEOUT(8), .BITSWAP(1'b1)) dut (
    .bus_clk     (bus_clk),
    .trn_reset_n (trn_reset_n),
    .icap_open   (icap_open),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .icap_busy   (icap_busy),
    .icap_ce_n   (icap_ce_n),
    .icap_wr_n   (icap_wr_n),
    .icap_i      (icap_i),
    .status      (status),
    .word_count  (word_count)
  );

  always #5 bus_clk = ~bus_clk;

  assign fifo_empty = (rd_ptr == wr_ptr);

  // Standard-mode FIFO: data appears the cycle after the pop
  always @(posedge bus_clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitor of pops, CE-low cycles and ICAP acceptances
  always @(negedge bus_clk) begin
    if (!icap_ce_n) ce_low_n <= ce_low_n + 1;
    if (!icap_ce_n && !icap_busy) begin
      acc_data[acc_n] <= icap_i;
      acc_cyc[acc_n]  <= cyc;
      acc_n           <= acc_n + 1;
    end
    if (fifo_rd_en) begin
      pop_cyc[pop_n] <= cyc;
      pop_n          <= pop_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] refSwap(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[(i / 8) * 8 + 7 - (i % 8)] = w[i];
    return r;
  endfunction

  function automatic logic [15:0] genWord(input int seed, input int i);
    return 16'(seed + i * 16'h0F1D);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic open, input logic busy);
    icap_open = open;
    icap_busy = busy;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic waitStatus(input string tag, input logic [1:0] exp);
    for (int n = 0; n < 200; n++) begin
      if (status == exp) break;
      step(1);
    end
    checkOutput(tag, 32'(status), 32'(exp));
  endtask

  initial begin
    int base;
    int pbase;
    int snap;
    int p;
    int n;
    logic [15:0] w;

    trn_reset_n = 1'b0;
    fifo_dout   = '0;
    applyStimulus(1'b0, 1'b0);
    step(2);
    checkOutput("rst_rd_en", 32'(fifo_rd_en), 0);
    checkOutput("rst_ce_n", 32'(icap_ce_n), 1);
    checkOutput("rst_wr_n", 32'(icap_wr_n), 1);
    checkOutput("rst_icap_i", 32'(icap_i), 0);
    checkOutput("rst_status", 32'(status), 0);
    checkOutput("rst_word_count", word_count, 0);
    trn_reset_n = 1'b1;
    step(2);
    checkOutput("idle_status", 32'(status), 0);

    // Two-word session with bit reversal inside each byte
    $display("[TB] two-word session");
    push(16'hAA99);
    push(16'h5566);
    base = acc_n;
    applyStimulus(1'b1, 1'b0);
    step(6);
    applyStimulus(1'b0, 1'b0);
    waitStatus("two_done", 2'b10);
    checkOutput("two_count", 32'(acc_n - base), 2);
    checkOutput("two_word0", 32'(acc_data[base]), 32'h5599);
    checkOutput("two_word1", 32'(acc_data[base + 1]), 32'hAA66);
    checkOutput("two_word_count", word_count, 2);
    checkOutput("two_ce_idle", 32'(icap_ce_n), 1);
    checkOutput("two_icap_hold", 32'(icap_i), 32'hAA66);

    // 64-word back-to-back stream
    $display("[TB] 64-word stream");
    for (int i = 0; i < 64; i++) push(genWord(16'h1357, i));
    base  = acc_n;
    pbase = pop_n;
    applyStimulus(1'b1, 1'b0);
    step(72);
    applyStimulus(1'b0, 1'b0);
    waitStatus("s64_done", 2'b10);
    checkOutput("s64_count", 32'(acc_n - base), 64);
    checkOutput("s64_latency", 32'(acc_cyc[base] - pop_cyc[pbase]), 2);
    checkOutput("s64_consecutive", 32'(acc_cyc[base + 63] - acc_cyc[base]), 63);
    for (int i = 0; i < 64; i++)
      checkOutput($sformatf("s64_word%0d", i), 32'(acc_data[base + i]),
                  32'(refSwap(genWord(16'h1357, i))));
    checkOutput("s64_word_count", word_count, 64);

    // Five busy cycles in mid-stream
    $display("[TB] busy stall");
    for (int i = 0; i < 10; i++) push(genWord(16'h0F00, i));
    base = acc_n;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (word_count != 3 && n < 50) begin
      step(1);
      n++;
    end
    checkOutput("busy_reach3", word_count, 3);
    applyStimulus(1'b1, 1'b1);
    snap = pop_n;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("busy_hold_data%0d", k), 32'(icap_i), 32'(refSwap(genWord(16'h0F00, 3))));
      checkOutput($sformatf("busy_hold_ce%0d", k), 32'(icap_ce_n), 0);
      step(1);
    end
    checkOutput("busy_extra_pops", 32'((pop_n - snap) <= 1), 1);
    applyStimulus(1'b1, 1'b0);
    step(12);
    applyStimulus(1'b0, 1'b0);
    waitStatus("busy_done", 2'b10);
    checkOutput("busy_count", 32'(acc_n - base), 10);
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("busy_word%0d", i), 32'(acc_data[base + i]),
                  32'(refSwap(genWord(16'h0F00, i))));
    checkOutput("busy_word_count", word_count, 10);

    // Busy held past the timeout of 8 cycles
    $display("[TB] busy timeout");
    for (int i = 0; i < 8; i++) push(genWord(16'h7001, i));
    base = acc_n;
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (word_count != 2 && n < 50) begin
      step(1);
      n++;
    end
    checkOutput("to_reach2", word_count, 2);
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (status != 2'b11 && n < 50) begin
      step(1);
      n++;
    end
    checkOutput("to_held_cycles", 32'(n), 8);
    checkOutput("to_ce_error", 32'(icap_ce_n), 1);
    checkOutput("to_wr_error", 32'(icap_wr_n), 1);
    snap = ce_low_n;
    step(12);
    checkOutput("to_fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
    checkOutput("to_no_ce", 32'(ce_low_n - snap), 0);
    checkOutput("to_status", 32'(status), 32'(2'b11));
    checkOutput("to_frozen_count", word_count, 2);
    checkOutput("to_accepted", 32'(acc_n - base), 2);
    applyStimulus(1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 1'b0);
    step(1);
    checkOutput("to_reopen_status", 32'(status), 1);
    checkOutput("to_reopen_count", word_count, 0);
    step(3);
    checkOutput("empty_load_status", 32'(status), 1);
    checkOutput("empty_load_ce", 32'(icap_ce_n), 1);

    // Close with three words arriving, reopen during FLUSH
    $display("[TB] close with queued words and reopen");
    base = acc_n;
    push(16'h0180);
    push(16'hF00F);
    push(16'h1234);
    applyStimulus(1'b0, 1'b0);
    step(1);
    checkOutput("fl_status_flush", 32'(status), 1);
    applyStimulus(1'b1, 1'b0);
    waitStatus("fl_done", 2'b10);
    checkOutput("fl_word_count", word_count, 3);
    checkOutput("fl_count", 32'(acc_n - base), 3);
    checkOutput("fl_word0", 32'(acc_data[base]), 32'h8001);
    checkOutput("fl_word1", 32'(acc_data[base + 1]), 32'h0FF0);
    checkOutput("fl_word2", 32'(acc_data[base + 2]), 32'h482C);
    step(1);
    checkOutput("fl_relaunch_status", 32'(status), 1);
    checkOutput("fl_relaunch_count", word_count, 0);

    // Reset pulse in the middle of a stream
    $display("[TB] reset mid-stream");
    for (int i = 0; i < 20; i++) push(genWord(16'h2468, i));
    step(6);
    trn_reset_n = 1'b0;
    #1;
    snap = ce_low_n;
    checkOutput("mr_rd_en", 32'(fifo_rd_en), 0);
    checkOutput("mr_ce_n", 32'(icap_ce_n), 1);
    checkOutput("mr_wr_n", 32'(icap_wr_n), 1);
    checkOutput("mr_icap_i", 32'(icap_i), 0);
    checkOutput("mr_status", 32'(status), 0);
    checkOutput("mr_word_count", word_count, 0);
    step(3);
    checkOutput("mr_no_ce", 32'(ce_low_n - snap), 0);
    trn_reset_n = 1'b1;
    p    = rd_ptr;
    base = acc_n;
    step(1);
    checkOutput("mr_load_status", 32'(status), 1);
    applyStimulus(1'b0, 1'b0);
    waitStatus("mr_done", 2'b10);
    w = mem[p];
    checkOutput("mr_first_word", 32'(acc_data[base]), 32'(refSwap(w)));
    checkOutput("mr_remaining", 32'(acc_n - base), 32'(wr_ptr - p));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
